// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage definitions: reset/bubble constants, IF/ID widths, fetch FSM states.
package instruction_fetch_unit_pkg;
  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;

  localparam logic [PC_W-1:0]    RESET_PC_DEFAULT = 64'h0000_0000_0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  function automatic logic is_aligned(input logic [PC_W-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bundle: pipeline controls, instruction ROM port and IF/ID outputs.
interface instruction_fetch_unit_if;
  import instruction_fetch_unit_pkg::*;

  logic                stall;
  logic                flush;
  logic                redirect_valid;
  logic [PC_W-1:0]     redirect_target;
  logic [PC_W-1:0]     imem_address;
  logic [INSTR_W-1:0]  imem_instruction;
  logic                ifid_valid;
  logic [PC_W-1:0]     ifid_pc;
  logic [PC_W-1:0]     ifid_pc_plus4;
  logic [INSTR_W-1:0]  ifid_instruction;
  logic                fetch_fault;

  modport master (
    input  stall, flush, redirect_valid, redirect_target, imem_instruction,
    output imem_address, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instruction, fetch_fault
  );

  modport slave (
    output stall, flush, redirect_valid, redirect_target, imem_instruction,
    input  imem_address, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instruction, fetch_fault
  );
endinterface

// File: rtl/instruction_fetch_unit_ifid_pipeline_register.sv
// IF/ID storage. capture loads a fetched word, bubble inserts a NOP, invalidate only drops valid.
module ifid_pipeline_register
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [INSTR_W-1:0] BUBBLE_INSTR = NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               capture_i,
  input  logic               bubble_i,
  input  logic               invalidate_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               valid_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [PC_W-1:0]    pc_plus4_o,
  output logic [INSTR_W-1:0] instr_o
);
  logic               valid_q, valid_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    pc_plus4_q, pc_plus4_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    if (capture_i) begin
      valid_d    = 1'b1;
      pc_d       = pc_i;
      pc_plus4_d = pc_i + 64'd4;
      instr_d    = instr_i;
    end else if (bubble_i) begin
      // pc fields deliberately keep their last value
      valid_d = 1'b0;
      instr_d = BUBBLE_INSTR;
    end else if (invalidate_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= BUBBLE_INSTR;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
    end
  end

  assign valid_o    = valid_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign instr_o    = instr_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch-stage front end: program counter, redirect/fault FSM and ROM addressing.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [INSTR_W-1:0] NOP_INSTR = instruction_fetch_unit_pkg::NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     rst,
  instruction_fetch_unit_if.master bus
);
  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            capture, bubble, invalidate;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    capture    = 1'b0;
    bubble     = 1'b0;
    invalidate = 1'b0;
    if (bus.redirect_valid) begin
      bubble = 1'b1;
      if (is_aligned(bus.redirect_target)) begin
        pc_d    = bus.redirect_target;
        state_d = RUN;
      end else begin
        state_d = FAULT;
      end
    end else if (state_q == FAULT) begin
      bubble = 1'b1;
    end else if (bus.stall) begin
      invalidate = bus.flush;
    end else if (bus.flush) begin
      pc_d   = pc_q + 64'd4;
      bubble = 1'b1;
    end else begin
      pc_d    = pc_q + 64'd4;
      capture = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  ifid_pipeline_register #(
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_ifid (
    .clk         (clk),
    .rst         (rst),
    .capture_i   (capture),
    .bubble_i    (bubble),
    .invalidate_i(invalidate),
    .pc_i        (pc_q),
    .instr_i     (bus.imem_instruction),
    .valid_o     (bus.ifid_valid),
    .pc_o        (bus.ifid_pc),
    .pc_plus4_o  (bus.ifid_pc_plus4),
    .instr_o     (bus.ifid_instruction)
  );

  // the fault flag is sticky exactly as long as the FSM sits in FAULT
  assign bus.imem_address = pc_q;
  assign bus.fetch_fault  = (state_q == FAULT);
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed scenarios followed by random control traffic.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam logic [63:0] RST_PC = 64'h0;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct {
    logic [63:0] addr;
    logic        valid;
    logic [63:0] ipc;
    logic [63:0] ip4;
    logic [31:0] ins;
    logic        fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [63:0] a);
    logic [31:0] w;
    w = a[33:2] * 32'h9E37_79B1;
    return w ^ 32'h5A00_00C3 ^ a[63:32];
  endfunction

  always_comb bus.imem_instruction = rom(bus.imem_address);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: architectural view of the fetch stage, updated per rising edge
  logic [63:0] m_pc = RST_PC;
  logic        m_fault = 1'b0;
  logic        m_v = 1'b0;
  logic [63:0] m_ipc = '0, m_ip4 = '0;
  logic [31:0] m_ins = NOP;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = RST_PC; m_fault = 1'b0;
      m_v = 1'b0; m_ipc = '0; m_ip4 = '0; m_ins = NOP;
    end else if (bus.redirect_valid) begin
      m_v = 1'b0; m_ins = NOP;
      if (bus.redirect_target % 4 == 0) begin
        m_pc = bus.redirect_target; m_fault = 1'b0;
      end else begin
        m_fault = 1'b1;
      end
    end else if (m_fault) begin
      m_v = 1'b0; m_ins = NOP;
    end else if (bus.stall) begin
      if (bus.flush) m_v = 1'b0;
    end else if (bus.flush) begin
      m_pc = m_pc + 4; m_v = 1'b0; m_ins = NOP;
    end else begin
      m_ipc = m_pc; m_ip4 = m_pc + 4; m_ins = rom(m_pc); m_v = 1'b1;
      m_pc = m_pc + 4;
    end
    exp_q.push_back('{addr: m_pc, valid: m_v, ipc: m_ipc, ip4: m_ip4, ins: m_ins, fault: m_fault});
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("imem_address", bus.imem_address, e.addr);
      chk("ifid_valid", {63'd0, bus.ifid_valid}, {63'd0, e.valid});
      chk("ifid_pc", bus.ifid_pc, e.ipc);
      chk("ifid_pc_plus4", bus.ifid_pc_plus4, e.ip4);
      chk("ifid_instruction", {32'd0, bus.ifid_instruction}, {32'd0, e.ins});
      chk("fetch_fault", {63'd0, bus.fetch_fault}, {63'd0, e.fault});
    end
  end

  task automatic step(input logic r, input logic s, input logic f, input logic rv,
                      input logic [63:0] t);
    rst = r;
    bus.stall = s;
    bus.flush = f;
    bus.redirect_valid = rv;
    bus.redirect_target = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] tgt;
    int          k;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = '0;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_valid", {63'd0, bus.ifid_valid}, 64'd0);
    chk("rst_addr", bus.imem_address, RST_PC);
    chk("rst_instr", {32'd0, bus.ifid_instruction}, {32'd0, NOP});

    step(0, 0, 0, 0, 0);
    chk("first_pc", bus.ifid_pc, 64'h0);
    chk("first_p4", bus.ifid_pc_plus4, 64'h4);
    step(0, 0, 0, 0, 0);
    chk("second_pc", bus.ifid_pc, 64'h4);
    chk("second_addr", bus.imem_address, 64'h8);

    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    chk("stall_addr", bus.imem_address, 64'h8);
    chk("stall_pc", bus.ifid_pc, 64'h4);
    step(0, 0, 0, 0, 0);
    chk("post_stall_pc", bus.ifid_pc, 64'h8);

    step(0, 1, 1, 1, 64'h40);
    chk("redir_valid", {63'd0, bus.ifid_valid}, 64'd0);
    chk("redir_addr", bus.imem_address, 64'h40);
    step(0, 0, 0, 0, 0);
    chk("redir_pc", bus.ifid_pc, 64'h40);
    chk("redir_v", {63'd0, bus.ifid_valid}, 64'd1);

    step(0, 0, 0, 1, 64'h42);
    for (int i = 0; i < 5; i++) step(0, i[0], i[1], 0, 0);
    chk("fault_flag", {63'd0, bus.fetch_fault}, 64'd1);
    chk("fault_addr", bus.imem_address, 64'h44);
    chk("fault_valid", {63'd0, bus.ifid_valid}, 64'd0);
    step(0, 1, 0, 1, 64'h80);
    chk("unfault", {63'd0, bus.fetch_fault}, 64'd0);
    step(0, 0, 0, 0, 0);
    chk("unfault_pc", bus.ifid_pc, 64'h80);

    step(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 0, 0, 0);
    chk("wrap_addr", bus.imem_address, 64'h0);
    chk("wrap_p4", bus.ifid_pc_plus4, 64'h0);
    chk("wrap_fault", {63'd0, bus.fetch_fault}, 64'd0);

    step(0, 0, 0, 1, 64'h6);
    step(1, 1, 1, 1, 64'h100);
    chk("midrst_addr", bus.imem_address, RST_PC);
    chk("midrst_fault", {63'd0, bus.fetch_fault}, 64'd0);
    chk("midrst_pc", bus.ifid_pc, 64'h0);

    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 2);
      if (k == 0)      tgt = {54'd0, $urandom_range(0, 255), 2'b00};
      else if (k == 1) tgt = {32'd0, $urandom, 32'd0} | 64'($urandom_range(1, 3));
      else             tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(0, 3));
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8, tgt);
    end
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
